// File: rtl/fifo_pkg.sv
// Shared constants, width helpers and parameter legality checks for the
// single-clock FIFO family.
package fifo_pkg;

    localparam int unsigned FIFO_MODE_STD  = 0;
    localparam int unsigned FIFO_MODE_FWFT = 1;

    // Pointer width: address bits plus one wrap bit.
    function automatic int unsigned ptr_w(input int unsigned depth);
        return $clog2(depth) + 1;
    endfunction

    function automatic bit depth_ok(input int unsigned depth);
        return (depth >= 2) && ((depth & (depth - 1)) == 0);
    endfunction

    function automatic bit levels_ok(input int unsigned depth, input int unsigned af,
                                     input int unsigned ae);
        return (af >= 1) && (af <= depth) && (ae <= depth - 1);
    endfunction

endpackage

// File: rtl/sync_fifo_ram.sv
// DEPTH x DWIDTH storage with one synchronous write port and one
// asynchronous read port. Contents are never reset.
module sync_fifo_ram #(
    parameter int unsigned DWIDTH = 8,
    parameter int unsigned DEPTH  = 16
) (
    input  logic                       clk,
    input  logic                       we,
    input  logic [$clog2(DEPTH)-1:0]   waddr,
    input  logic [DWIDTH-1:0]          wdata,
    input  logic [$clog2(DEPTH)-1:0]   raddr,
    output logic [DWIDTH-1:0]          rdata
);

    logic [DWIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/sync_fifo_ctl.sv
// Single-clock FIFO controller: pointers, occupancy count, status flags,
// sticky error flags and standard/FWFT read data path.
module sync_fifo_ctl
    import fifo_pkg::*;
#(
    parameter int unsigned DWIDTH   = 8,
    parameter int unsigned DEPTH    = 16,
    parameter int unsigned FWFT     = FIFO_MODE_STD,
    parameter int unsigned AF_LEVEL = DEPTH - 2,
    parameter int unsigned AE_LEVEL = 2
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     flush,
    input  logic                     w_en,
    input  logic [DWIDTH-1:0]        wdata,
    output logic                     wfull,
    output logic                     almost_full,
    input  logic                     r_en,
    output logic [DWIDTH-1:0]        rdata,
    output logic                     rempty,
    output logic                     almost_empty,
    output logic [$clog2(DEPTH):0]   count,
    input  logic                     err_clr,
    output logic                     overflow,
    output logic                     underflow
);

    localparam int unsigned AWIDTH = $clog2(DEPTH);
    localparam int unsigned PW     = ptr_w(DEPTH);

    localparam logic [PW-1:0] ONE_CNT   = PW'(1);
    localparam logic [PW-1:0] DEPTH_CNT = PW'(DEPTH);
    localparam logic [PW-1:0] AF_CNT    = PW'(AF_LEVEL);
    localparam logic [PW-1:0] AE_CNT    = PW'(AE_LEVEL);

    if (!depth_ok(DEPTH)) begin : g_bad_depth
        $error("sync_fifo_ctl: DEPTH must be a power of two and at least 2");
    end
    if (!levels_ok(DEPTH, AF_LEVEL, AE_LEVEL)) begin : g_bad_levels
        $error("sync_fifo_ctl: AF_LEVEL must be 1..DEPTH and AE_LEVEL 0..DEPTH-1");
    end

    logic [PW-1:0]     wptr_q;
    logic [PW-1:0]     rptr_q;
    logic [PW-1:0]     count_q;
    logic              overflow_q;
    logic              underflow_q;
    logic              wr_acc;
    logic              rd_acc;
    logic [DWIDTH-1:0] ram_rdata;

    // Flags come straight from the registered count so they never glitch.
    assign rempty       = (count_q == '0);
    assign wfull        = (count_q == DEPTH_CNT);
    assign almost_full  = (count_q >= AF_CNT);
    assign almost_empty = (count_q <= AE_CNT);
    assign count        = count_q;
    assign overflow     = overflow_q;
    assign underflow    = underflow_q;

    assign wr_acc = w_en & ~wfull & ~flush;
    assign rd_acc = r_en & ~rempty & ~flush;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else if (flush) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            if (wr_acc) begin
                wptr_q <= wptr_q + ONE_CNT;
            end
            if (rd_acc) begin
                rptr_q <= rptr_q + ONE_CNT;
            end
            if (wr_acc && !rd_acc) begin
                count_q <= count_q + ONE_CNT;
            end else if (rd_acc && !wr_acc) begin
                count_q <= count_q - ONE_CNT;
            end
        end
    end

    // A new error in the same cycle as err_clr keeps the flag set.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else if (!flush) begin
            overflow_q  <= (w_en & wfull) | (overflow_q & ~err_clr);
            underflow_q <= (r_en & rempty) | (underflow_q & ~err_clr);
        end
    end

    sync_fifo_ram #(
        .DWIDTH (DWIDTH),
        .DEPTH  (DEPTH)
    ) u_ram (
        .clk   (clk),
        .we    (wr_acc),
        .waddr (wptr_q[AWIDTH-1:0]),
        .wdata (wdata),
        .raddr (rptr_q[AWIDTH-1:0]),
        .rdata (ram_rdata)
    );

    if (FWFT == FIFO_MODE_FWFT) begin : g_fwft
        assign rdata = ram_rdata;
    end else begin : g_std
        logic [DWIDTH-1:0] rdata_q;

        always_ff @(posedge clk) begin
            if (!rst_n) begin
                rdata_q <= '0;
            end else if (rd_acc) begin
                rdata_q <= ram_rdata;
            end
        end

        assign rdata = rdata_q;
    end

    // Pointer distance must always equal the occupancy count.
    a_ptr_count: assert property (@(posedge clk) disable iff (!rst_n)
        (PW'(wptr_q - rptr_q) == count_q));

endmodule

// File: tb/tb_sync_fifo_ctl.sv
// Directed bench for sync_fifo_ctl: a driver pushes expected read data into
// scoreboard queues, a separate monitor pops and compares on each accepted read.
module tb_sync_fifo_ctl;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       flush = 1'b0, w_en = 1'b0, r_en = 1'b0, err_clr = 1'b0;
    logic [7:0] wdata = '0;
    logic       wfull, almost_full, rempty, almost_empty, overflow, underflow;
    logic [7:0] rdata;
    logic [4:0] count;

    logic       flush_f = 1'b0, w_en_f = 1'b0, r_en_f = 1'b0, err_clr_f = 1'b0;
    logic [7:0] wdata_f = '0;
    logic       wfull_f, almost_full_f, rempty_f, almost_empty_f, overflow_f, underflow_f;
    logic [7:0] rdata_f;
    logic [4:0] count_f;

    int         checks = 0;
    int         errors = 0;
    int         mcount = 0;
    bit         mov = 0, mun = 0;
    logic [7:0] sb[$];
    logic [7:0] sb_f[$];

    always #5 clk = ~clk;

    sync_fifo_ctl #(.DWIDTH(8), .DEPTH(16), .FWFT(0)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush), .w_en(w_en), .wdata(wdata),
        .wfull(wfull), .almost_full(almost_full), .r_en(r_en), .rdata(rdata),
        .rempty(rempty), .almost_empty(almost_empty), .count(count),
        .err_clr(err_clr), .overflow(overflow), .underflow(underflow)
    );

    sync_fifo_ctl #(.DWIDTH(8), .DEPTH(16), .FWFT(1)) dut_f (
        .clk(clk), .rst_n(rst_n), .flush(flush_f), .w_en(w_en_f), .wdata(wdata_f),
        .wfull(wfull_f), .almost_full(almost_full_f), .r_en(r_en_f), .rdata(rdata_f),
        .rempty(rempty_f), .almost_empty(almost_empty_f), .count(count_f),
        .err_clr(err_clr_f), .overflow(overflow_f), .underflow(underflow_f)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: sample handshakes 1 time unit before the edge, compare after it.
    initial begin
        bit fire, fire_f;
        forever begin
            @(negedge clk);
            #4;
            fire   = rst_n && !flush && r_en && !rempty;
            fire_f = rst_n && !flush_f && r_en_f && !rempty_f;
            if (fire_f) begin
                if (sb_f.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL fwft_unexpected_pop: got 0x%0h expected none", rdata_f);
                end else begin
                    chk("fwft_rdata", rdata_f, sb_f.pop_front());
                end
            end
            @(posedge clk);
            #1;
            if (fire) begin
                if (sb.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL std_unexpected_pop: got 0x%0h expected none", rdata);
                end else begin
                    chk("std_rdata", rdata, sb.pop_front());
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

    // One clock of stimulus on the standard instance plus model update.
    task automatic step(input bit we, input logic [7:0] wd, input bit re,
                        input bit fl, input bit ec);
        bit wa, ra;
        w_en = we; wdata = wd; r_en = re; flush = fl; err_clr = ec;
        if (fl) begin
            sb.delete();
            mcount = 0;
        end else begin
            wa  = we && (mcount < 16);
            ra  = re && (mcount > 0);
            mov = (we && mcount == 16) || (mov && !ec);
            mun = (re && mcount == 0) || (mun && !ec);
            if (wa) sb.push_back(wd);
            mcount = mcount + int'(wa) - int'(ra);
        end
        @(negedge clk);
        w_en = 0; r_en = 0; flush = 0; err_clr = 0;
    endtask

    task automatic do_reset(input bit we);
        rst_n = 1'b0; w_en = we; wdata = 8'h99;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1; w_en = 0;
        sb.delete(); sb_f.delete();
        mcount = 0; mov = 0; mun = 0;
    endtask

    task automatic check_state(input string tag);
        chk({tag, ".count"}, count, mcount);
        chk({tag, ".wfull"}, wfull, mcount == 16);
        chk({tag, ".rempty"}, rempty, mcount == 0);
        chk({tag, ".almost_full"}, almost_full, mcount >= 14);
        chk({tag, ".almost_empty"}, almost_empty, mcount <= 2);
        chk({tag, ".overflow"}, overflow, mov);
        chk({tag, ".underflow"}, underflow, mun);
    endtask

    initial begin
        do_reset(1'b0);
        check_state("reset");
        chk("reset.rdata", rdata, 8'h00);

        for (int i = 0; i < 16; i++) begin
            step(1, 8'(i), 0, 0, 0);
            check_state($sformatf("fill%0d", i));
        end
        step(1, 8'hFF, 0, 0, 0);
        check_state("overflow_write");
        chk("ovf.count_stays", count, 16);

        for (int i = 0; i < 16; i++) begin
            step(0, 8'h00, 1, 0, 0);
            check_state($sformatf("drain%0d", i));
        end
        step(0, 8'h00, 1, 0, 0);
        check_state("underflow_read");
        chk("rdata_hold", rdata, 8'h0F);

        step(0, 8'h00, 0, 0, 1);
        check_state("err_clr");
        for (int i = 0; i < 5; i++) step(1, 8'(8'h20 + i), 0, 0, 0);
        for (int i = 0; i < 40; i++) begin
            step(1, 8'(8'h40 + i), 1, 0, 0);
            check_state($sformatf("wrap%0d", i));
        end
        for (int i = 0; i < 5; i++) step(0, 8'h00, 1, 0, 0);
        check_state("wrap_drained");

        for (int i = 0; i < 7; i++) step(1, 8'(8'h70 + i), 0, 0, 0);
        step(1, 8'hEE, 1, 1, 0);
        check_state("flush");
        step(1, 8'h3C, 0, 0, 0);
        step(0, 8'h00, 1, 0, 0);
        chk("after_flush.rdata", rdata, 8'h3C);
        chk("sb_drained", sb.size(), 0);

        step(0, 8'h00, 1, 0, 1);
        check_state("clr_vs_underflow");
        chk("underflow_set_wins", underflow, 1'b1);
        step(0, 8'h00, 0, 0, 1);
        check_state("clr_alone");

        for (int i = 0; i < 9; i++) step(1, 8'(8'h90 + i), 0, 0, 0);
        check_state("pre_reset");
        do_reset(1'b1);
        check_state("mid_reset");
        chk("mid_reset.rdata", rdata, 8'h00);

        w_en_f = 1; wdata_f = 8'hA5;
        @(negedge clk);
        w_en_f = 0;
        chk("fwft.rempty_after_write", rempty_f, 1'b0);
        chk("fwft.rdata_shown", rdata_f, 8'hA5);
        sb_f.push_back(8'hA5);
        r_en_f = 1;
        @(negedge clk);
        r_en_f = 0;
        chk("fwft.rempty_after_pop", rempty_f, 1'b1);
        chk("fwft.sb_drained", sb_f.size(), 0);
        chk("fwft.underflow", underflow_f, 1'b0);

        @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
